// File: rtl/gcm_pkg.sv
// gcm_pkg: shared GF(2^128) types, GHASH FSM states and length-block helper.
package gcm_pkg;
    typedef logic [127:0] gf128_t;
    typedef enum logic [1:0] {IDLE, ACCUM, LEN, DONE} ghash_state_e;
    localparam logic [7:0] GF128_R = 8'h87;
    function automatic gf128_t len_block(input logic [63:0] aad_bits, input logic [63:0] ct_bits);
        return {aad_bits, ct_bits};
    endfunction
endpackage

// File: rtl/ghash_accum_if.sv
// ghash_accum_if: block input, subkey load, start and tag handshake signals of the GHASH accumulator.
interface ghash_accum_if;
    import gcm_pkg::*;
    logic       h_load;
    gf128_t     h_in;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    gf128_t     in_data;
    logic       in_is_aad;
    logic [4:0] in_bytes;
    logic       in_last;
    logic       tag_valid;
    logic       tag_ready;
    gf128_t     tag;
    logic       busy;
    modport master (
        output h_load, h_in, start, in_valid, in_data, in_is_aad, in_bytes, in_last, tag_ready,
        input  in_ready, tag_valid, tag, busy
    );
    modport slave (
        input  h_load, h_in, start, in_valid, in_data, in_is_aad, in_bytes, in_last, tag_ready,
        output in_ready, tag_valid, tag, busy
    );
endinterface

// File: rtl/gcm_mult.sv
// gcm_mult: combinational GF(2^128) multiply, bit i = coeff of a^i, modulus a^128+a^7+a^2+a+1.
module gcm_mult
    import gcm_pkg::*;
(
    input  gf128_t x_i,
    input  gf128_t y_i,
    output gf128_t z_o
);
    gf128_t v;
    always_comb begin
        z_o = '0;
        v   = x_i;
        for (int i = 0; i < 128; i++) begin
            z_o = y_i[i] ? z_o ^ v : z_o;
            // v tracks x * a^(i+1) reduced mod the field polynomial
            v   = {v[126:0], 1'b0} ^ (v[127] ? {120'b0, GF128_R} : 128'b0);
        end
    end
endmodule

// File: rtl/ghash_accum.sv
// ghash_accum: GHASH accumulator Y <= (Y ^ block) * H, one block per cycle, emits Y as the tag.
// GHASH_LEN_BLOCK_EN: when defined, counts AAD/CT bits and appends the len(A)||len(C) block itself.
module ghash_accum
    import gcm_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int LEN_W  = 64
) (
    input logic         clk,
    input logic         rst,
    ghash_accum_if.slave bus
);
    if (DATA_W != 128) begin : g_bad_width
        $error("ghash_accum: DATA_W must be 128");
    end

    ghash_state_e state_q, state_d;
    gf128_t       y_q, y_d, h_q, h_d, mult_x, mult_p;
    logic         hs, nonempty;

    assign hs       = bus.in_valid & bus.in_ready;
    assign nonempty = bus.in_bytes != 5'd0;

`ifdef GHASH_LEN_BLOCK_EN
    localparam ghash_state_e AFTER_LAST = LEN;
    logic [LEN_W-1:0] aad_q, aad_d, ct_q, ct_d, blk_bits;
    assign blk_bits = LEN_W'({(bus.in_bytes > 5'd16 ? 5'd16 : bus.in_bytes), 3'b000});
    assign mult_x   = (state_q == LEN) ? y_q ^ len_block(64'(aad_q), 64'(ct_q)) : y_q ^ bus.in_data;
    always_comb begin
        aad_d = (state_q == IDLE && bus.start) ? '0 : (hs && nonempty && bus.in_is_aad) ? aad_q + blk_bits : aad_q;
        ct_d  = (state_q == IDLE && bus.start) ? '0 : (hs && nonempty && !bus.in_is_aad) ? ct_q + blk_bits : ct_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            aad_q <= '0;
            ct_q  <= '0;
        end else begin
            aad_q <= aad_d;
            ct_q  <= ct_d;
        end
    end
`else
    localparam ghash_state_e AFTER_LAST = DONE;
    localparam int unused_len_w = LEN_W;
    logic unused_is_aad;
    assign unused_is_aad = bus.in_is_aad;
    assign mult_x        = y_q ^ bus.in_data;
`endif

    gcm_mult u_mult (.x_i(mult_x), .y_i(h_q), .z_o(mult_p));

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        h_d     = h_q;
        case (state_q)
            IDLE: begin
                h_d     = bus.h_load ? bus.h_in : h_q;
                y_d     = bus.start ? '0 : y_q;
                state_d = bus.start ? ACCUM : IDLE;
            end
            ACCUM: begin
                y_d     = (hs && nonempty) ? mult_p : y_q;
                state_d = (hs && bus.in_last) ? AFTER_LAST : ACCUM;
            end
            LEN: begin
                y_d     = mult_p;
                state_d = DONE;
            end
            DONE:    state_d = bus.tag_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            y_q     <= '0;
            h_q     <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            h_q     <= h_d;
        end
    end

    assign bus.in_ready  = state_q == ACCUM;
    assign bus.tag_valid = state_q == DONE;
    assign bus.tag       = y_q;
    assign bus.busy      = state_q != IDLE;
endmodule
